// File: rtl/header_extract_pkg.sv
// ----------------------------------------------------------------------------
// header_extract_pkg : shared types and helpers for the header extractor
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package header_extract_pkg;

  typedef enum logic [0:0] {
    HEADER = 1'b0,
    DATA   = 1'b1
  } state_t;

  localparam int HDR_LSB   = 16;
  localparam int HDR_WIDTH = 16;
  localparam int KEEP_MAX  = 64;

  // Callers zero-extend their tkeep to KEEP_MAX bits.
  function automatic logic [HDR_WIDTH-1:0] keep_popcount(input logic [KEEP_MAX-1:0] keep);
    logic [HDR_WIDTH-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      cnt = cnt + {{(HDR_WIDTH-1){1'b0}}, keep[i]};
    end
    return cnt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/header_extract_if.sv
// ----------------------------------------------------------------------------
// header_extract_if : framed input, payload output, meta output and error flag
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface header_extract_if #(
  parameter int TDATA_BYTES = 8,
  parameter int TKEEP_WIDTH = TDATA_BYTES
);

  logic                     target_tvalid;
  logic                     target_tready;
  logic [8*TDATA_BYTES-1:0] target_tdata;
  logic [TKEEP_WIDTH-1:0]   target_tkeep;
  logic                     target_tlast;

  logic                     initiator_tvalid;
  logic                     initiator_tready;
  logic [8*TDATA_BYTES-1:0] initiator_tdata;
  logic [TKEEP_WIDTH-1:0]   initiator_tkeep;
  logic                     initiator_tlast;

  logic                     meta_tvalid;
  logic                     meta_tready;
  logic [15:0]              meta_tdata;

  logic                     len_err;

  modport slave (
    input  target_tvalid, target_tdata, target_tkeep, target_tlast,
    output target_tready,
    output initiator_tvalid, initiator_tdata, initiator_tkeep, initiator_tlast,
    input  initiator_tready,
    output meta_tvalid, meta_tdata,
    input  meta_tready,
    output len_err
  );

  modport master (
    output target_tvalid, target_tdata, target_tkeep, target_tlast,
    input  target_tready,
    input  initiator_tvalid, initiator_tdata, initiator_tkeep, initiator_tlast,
    output initiator_tready,
    input  meta_tvalid, meta_tdata,
    output meta_tready,
    input  len_err
  );

endinterface

`default_nettype wire

// File: rtl/header_extract_len_check.sv
// ----------------------------------------------------------------------------
// header_extract_len_check : counts payload bytes and flags a header length mismatch
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module header_extract_len_check
  import header_extract_pkg::*;
#(
  parameter int TKEEP_WIDTH = 8
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   hdr_hs,
  input  logic                   dat_hs,
  input  logic [HDR_WIDTH-1:0]   hdr_len,
  input  logic [TKEEP_WIDTH-1:0] keep,
  input  logic                   last,
  output logic                   len_err
);

  logic [HDR_WIDTH-1:0] r_count;
  logic [HDR_WIDTH-1:0] r_len;
  logic                 r_len_err;
  logic [HDR_WIDTH-1:0] w_count_next;
  logic                 w_mismatch;

  // The final beat's bytes are included before comparing, so compare against the next count.
  always_comb begin
    w_count_next = r_count + keep_popcount(KEEP_MAX'(keep));
    w_mismatch   = 1'b0;
    if (hdr_hs && last) begin
      w_mismatch = (hdr_len != '0);
    end else if (dat_hs && last) begin
      w_mismatch = (w_count_next != r_len);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_count   <= '0;
      r_len     <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_len_err <= w_mismatch;
      if (hdr_hs) begin
        r_count <= '0;
        r_len   <= hdr_len;
      end else if (dat_hs) begin
        r_count <= w_count_next;
      end
    end
  end

  assign len_err = r_len_err;

endmodule

`default_nettype wire

// File: rtl/header_extract.sv
// ----------------------------------------------------------------------------
// header_extract : strips the length header beat; optional check via HEADER_EXTRACT_LEN_CHECK_EN
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module header_extract
  import header_extract_pkg::*;
#(
  parameter int TDATA_BYTES = 8,
  parameter int TKEEP_WIDTH = TDATA_BYTES
) (
  input  logic           aclk,
  input  logic           areset,
  header_extract_if.slave bus
);

  state_t                   r_state;
  state_t                   w_state_next;
  logic                     w_tready;
  logic                     w_hs;
  logic                     w_hdr_hs;
  logic                     w_dat_hs;

  logic                     r_meta_valid;
  logic [HDR_WIDTH-1:0]     r_meta_data;
  logic                     r_init_valid;
  logic [8*TDATA_BYTES-1:0] r_init_data;
  logic [TKEEP_WIDTH-1:0]   r_init_keep;
  logic                     r_init_last;

  assign w_hs     = bus.target_tvalid && w_tready;
  assign w_hdr_hs = w_hs && (r_state == HEADER);
  assign w_dat_hs = w_hs && (r_state == DATA);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= HEADER;
    end else begin
      r_state <= w_state_next;
    end
  end

  // An empty packet (header with tlast) keeps the FSM in HEADER.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      HEADER:  if (w_hdr_hs && !bus.target_tlast) w_state_next = DATA;
      DATA:    if (w_dat_hs && bus.target_tlast)  w_state_next = HEADER;
      default: w_state_next = HEADER;
    endcase
  end

  always_comb begin
    w_tready = 1'b0;
    case (r_state)
      HEADER:  w_tready = !r_meta_valid || bus.meta_tready;
      DATA:    w_tready = !r_init_valid || bus.initiator_tready;
      default: w_tready = 1'b0;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_meta_valid <= 1'b0;
      r_init_valid <= 1'b0;
    end else begin
      if (w_hdr_hs) begin
        r_meta_valid <= 1'b1;
      end else if (bus.meta_tready) begin
        r_meta_valid <= 1'b0;
      end
      if (w_dat_hs) begin
        r_init_valid <= 1'b1;
      end else if (bus.initiator_tready) begin
        r_init_valid <= 1'b0;
      end
    end
  end

  // Payload and meta holding registers need no reset; their valids qualify them.
  always_ff @(posedge aclk) begin
    if (w_hdr_hs) begin
      r_meta_data <= bus.target_tdata[HDR_LSB +: HDR_WIDTH];
    end
    if (w_dat_hs) begin
      r_init_data <= bus.target_tdata;
      r_init_keep <= bus.target_tkeep;
      r_init_last <= bus.target_tlast;
    end
  end

  assign bus.target_tready    = w_tready;
  assign bus.meta_tvalid      = r_meta_valid;
  assign bus.meta_tdata       = r_meta_data;
  assign bus.initiator_tvalid = r_init_valid;
  assign bus.initiator_tdata  = r_init_data;
  assign bus.initiator_tkeep  = r_init_keep;
  assign bus.initiator_tlast  = r_init_last;

`ifdef HEADER_EXTRACT_LEN_CHECK_EN
  header_extract_len_check #(
    .TKEEP_WIDTH(TKEEP_WIDTH)
  ) u_len_check (
    .aclk    (aclk),
    .areset  (areset),
    .hdr_hs  (w_hdr_hs),
    .dat_hs  (w_dat_hs),
    .hdr_len (bus.target_tdata[HDR_LSB +: HDR_WIDTH]),
    .keep    (bus.target_tkeep),
    .last    (bus.target_tlast),
    .len_err (bus.len_err)
  );
`else
  assign bus.len_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_header_extract.sv
// ----------------------------------------------------------------------------
// tb_header_extract : randomized self-checking bench with a packet-level scoreboard
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_header_extract;

  localparam int TB = 8;
  localparam int KW = 8;
`ifdef HEADER_EXTRACT_LEN_CHECK_EN
  localparam bit LEN_CHK = 1'b1;
`else
  localparam bit LEN_CHK = 1'b0;
`endif

  logic aclk = 1'b0;
  logic areset;

  header_extract_if #(.TDATA_BYTES(TB), .TKEEP_WIDTH(KW)) bus ();

  header_extract #(.TDATA_BYTES(TB), .TKEEP_WIDTH(KW)) dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_meta[$];
  logic [72:0] exp_pay[$];
  logic [7:0]  pkt_keep[$];
  bit cur_hdr, cur_err, meta_hold, rnd_ready, gaps;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge aclk) begin
    #2;
    bus.meta_tready      = meta_hold ? 1'b0 : (rnd_ready ? 1'($urandom) : 1'b1);
    bus.initiator_tready = rnd_ready ? 1'($urandom) : 1'b1;
  end

  // Output monitor: handshakes seen at negedge complete on the following posedge.
  logic        pend_meta, pend_init, pend_err, m_stall, i_stall;
  logic [15:0] m_prev;
  logic [72:0] i_prev;
  logic [72:0] e;

  always @(negedge aclk) begin
    if (areset) begin
      pend_meta <= 1'b0; pend_init <= 1'b0; pend_err <= 1'b0;
      m_stall   <= 1'b0; i_stall   <= 1'b0;
    end else begin
      if (pend_meta) check("meta_latency", bus.meta_tvalid, 1);
      if (pend_init) check("pay_latency", bus.initiator_tvalid, 1);
      check("len_err", bus.len_err, pend_err);
      if (m_stall) check("meta_hold", {bus.meta_tvalid, bus.meta_tdata}, {1'b1, m_prev});
      if (i_stall) begin
        check("pay_hold_data", bus.initiator_tdata, i_prev[63:0]);
        check("pay_hold_ctl", {bus.initiator_tvalid, bus.initiator_tlast, bus.initiator_tkeep},
              {1'b1, i_prev[72:64]});
      end
      if (bus.meta_tvalid && bus.meta_tready) begin
        if (exp_meta.size() == 0) check("meta_extra", 1, 0);
        else check("meta_len", bus.meta_tdata, exp_meta.pop_front());
      end
      if (bus.initiator_tvalid && bus.initiator_tready) begin
        if (exp_pay.size() == 0) check("pay_extra", 1, 0);
        else begin
          e = exp_pay.pop_front();
          check("pay_data", bus.initiator_tdata, e[63:0]);
          check("pay_keep_last", {bus.initiator_tlast, bus.initiator_tkeep}, e[72:64]);
        end
      end
      pend_meta <= bus.target_tvalid && bus.target_tready && cur_hdr;
      pend_init <= bus.target_tvalid && bus.target_tready && !cur_hdr;
      pend_err  <= bus.target_tvalid && bus.target_tready && cur_err;
      m_stall   <= bus.meta_tvalid && !bus.meta_tready;
      m_prev    <= bus.meta_tdata;
      i_stall   <= bus.initiator_tvalid && !bus.initiator_tready;
      i_prev    <= {bus.initiator_tlast, bus.initiator_tkeep, bus.initiator_tdata};
    end
  end

  // Called at posedge+1; returns at posedge+1 after the handshake edge.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                           input bit hdr, input bit err);
    int n = 0;
    bus.target_tvalid = 1'b1;
    bus.target_tdata  = d;
    bus.target_tkeep  = k;
    bus.target_tlast  = l;
    cur_hdr = hdr;
    cur_err = err;
    @(negedge aclk);
    while (!bus.target_tready && n < 300) begin
      n++;
      @(negedge aclk);
    end
    if (!bus.target_tready) check("tready_timeout", 0, 1);
    @(posedge aclk);
    #1;
    bus.target_tvalid = 1'b0;
    cur_hdr = 1'b0;
    cur_err = 1'b0;
  endtask

  task automatic idle_gap();
    if (gaps) repeat ($urandom_range(0, 2)) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic send_pkt(input logic [15:0] len);
    logic [15:0] sum;
    logic [63:0] d;
    int          nb;
    bit          err;
    sum = 16'd0;
    nb  = pkt_keep.size();
    foreach (pkt_keep[i]) sum = sum + 16'($countones(pkt_keep[i]));
    err = LEN_CHK && (sum != len);
    exp_meta.push_back(len);
    send_beat({$urandom, len, 16'($urandom)}, 8'($urandom), nb == 0, 1'b1, err && nb == 0);
    for (int i = 0; i < nb; i++) begin
      d = {$urandom, $urandom};
      exp_pay.push_back({(i == nb - 1), pkt_keep[i], d});
      idle_gap();
      send_beat(d, pkt_keep[i], i == nb - 1, 1'b0, err && (i == nb - 1));
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_meta.size() != 0 || exp_pay.size() != 0) && n < 1000) begin
      n++;
      @(negedge aclk);
    end
    check("drain_meta", exp_meta.size(), 0);
    check("drain_pay", exp_pay.size(), 0);
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] sum;
    logic [15:0] len;
    logic [7:0]  k;
    int          nb;

    areset = 1'b1;
    bus.target_tvalid = 1'b0; bus.target_tdata = '0; bus.target_tkeep = '0; bus.target_tlast = 1'b0;
    bus.meta_tready = 1'b1; bus.initiator_tready = 1'b1;
    cur_hdr = 1'b0; cur_err = 1'b0; meta_hold = 1'b0; rnd_ready = 1'b0; gaps = 1'b0;

    repeat (2) @(negedge aclk);
    check("rst_init_valid", bus.initiator_tvalid, 0);
    check("rst_meta_valid", bus.meta_tvalid, 0);
    check("rst_len_err", bus.len_err, 0);
    areset = 1'b0;
    @(posedge aclk);
    #1;

    // Three full beats, length matches.
    pkt_keep = '{8'hFF, 8'hFF, 8'hFF};
    send_pkt(16'd24);
    wait_drain();

    // Meta stalled while packet 1 payload flows and packet 2 header waits.
    meta_hold = 1'b1;
    fork
      begin
        pkt_keep = '{8'hFF, 8'hFF};
        send_pkt(16'd16);
        pkt_keep = '{8'hFF};
        send_pkt(16'd8);
      end
      begin
        repeat (8) @(negedge aclk);
        check("hdr_stall_tready", bus.target_tready, 0);
        check("hdr_stall_meta", bus.meta_tvalid, 1);
        repeat (2) @(posedge aclk);
        #1;
        meta_hold = 1'b0;
      end
    join
    wait_drain();

    // Empty packet followed by a normal one.
    pkt_keep.delete();
    send_pkt(16'd0);
    pkt_keep = '{8'hFF};
    send_pkt(16'd8);
    wait_drain();

    // Short and exact byte counts against a length of 20.
    pkt_keep = '{8'hFF, 8'hFF, 8'h03};
    send_pkt(16'd20);
    pkt_keep = '{8'hFF, 8'hFF, 8'h0F};
    send_pkt(16'd20);
    pkt_keep.delete();
    send_pkt(16'd5);
    wait_drain();

    // Randomized traffic with random backpressure and idle gaps.
    rnd_ready = 1'b1;
    gaps = 1'b1;
    for (int p = 0; p < 60; p++) begin
      nb = $urandom_range(0, 4);
      pkt_keep.delete();
      sum = 16'd0;
      for (int b = 0; b < nb; b++) begin
        k = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'hFF;
        pkt_keep.push_back(k);
        sum = sum + 16'($countones(k));
      end
      len = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 40)) : sum;
      send_pkt(len);
    end
    rnd_ready = 1'b0;
    gaps = 1'b0;
    wait_drain();

    // Reset during beat 2 of 4; the next beat must be taken as a header.
    pkt_keep = '{8'hFF};
    exp_meta.push_back(16'd32);
    send_beat({32'h0, 16'd32, 16'h0}, 8'hFF, 1'b0, 1'b1, 1'b0);
    exp_pay.push_back({1'b0, 8'hFF, 64'h1111_2222_3333_4444});
    send_beat(64'h1111_2222_3333_4444, 8'hFF, 1'b0, 1'b0, 1'b0);
    bus.target_tvalid = 1'b1;
    bus.target_tdata  = 64'h5555_6666_7777_8888;
    bus.target_tkeep  = 8'hFF;
    bus.target_tlast  = 1'b0;
    #2;
    areset = 1'b1;
    #1;
    check("mid_rst_init_valid", bus.initiator_tvalid, 0);
    check("mid_rst_meta_valid", bus.meta_tvalid, 0);
    check("mid_rst_len_err", bus.len_err, 0);
    bus.target_tvalid = 1'b0;
    exp_meta.delete();
    exp_pay.delete();
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk);
    #1;
    pkt_keep = '{8'hFF, 8'h0F};
    send_pkt(16'd12);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
